// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the 16-bit CPU pipeline MEM stage.
// Used by memory_access_stage, its data-memory interface and its wait timer.
package cpu_pipe_pkg;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int TIMEOUT_CYC_DEFAULT = 15;

  // Writeback source select; encoding 3 is reserved and behaves as WB_ALU
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2
  } wb_sel_e;

  // Data-memory access sequencing
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-RAM req/ready bus between the MEM stage (master) and the data memory (slave).
interface memory_access_stage_if #(
  parameter int DW = cpu_pipe_pkg::DW
);

  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );

endinterface

// File: rtl/memory_access_stage_wait_timer.sv
// mem_wait_timer: counts wait-state cycles of a data-memory access.
// tc is high during the TERMINAL-th counted wait cycle, i.e. when the
// access has waited as long as it is allowed to.
module mem_wait_timer #(
  parameter int unsigned TERMINAL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear has priority; otherwise count one per enabled cycle
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register, cleared by the active-low async reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == 8'(TERMINAL - 1));

endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM stage of the 16-bit pipelined CPU.
// Runs data-RAM loads/stores over a req/ready bus, stalls the front of the
// pipe during wait states, aborts after TIMEOUT_CYC wait cycles, and owns
// the MEM/WB pipeline register.
// Optional feature macro: MEMORY_ACCESS_STAGE_STALL_CNT_EN (stall-cycle counter).
module memory_access_stage #(
  parameter int DW          = cpu_pipe_pkg::DW,
  parameter int RW          = cpu_pipe_pkg::RW,
  parameter int TIMEOUT_CYC = cpu_pipe_pkg::TIMEOUT_CYC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wre_memory,
  input  logic [1:0]                   wb_sel_memory,
  input  logic                         write_memory_enable_mem,
  input  logic [DW-1:0]                alu_result_memory,
  input  logic [DW-1:0]                srcB_memory,
  input  logic [DW-1:0]                pc_inc_memory,
  input  logic [RW-1:0]                rd_memory,
  memory_access_stage_if.master        dmem_bus,
  output logic                         stall_mem,
  output logic                         wre_writeback,
  output logic [RW-1:0]                rd_writeback,
  output logic [DW-1:0]                writeback_data,
  output logic                         mem_fault,
  output logic [15:0]                  stall_count
);

  import cpu_pipe_pkg::*;

  mem_state_e    state_q, state_d;
  logic          mem_op;
  logic          fire;
  logic          tc;
  logic          timer_clear;
  logic          timer_enable;
  logic          wre_writeback_q, wre_writeback_d;
  logic [RW-1:0] rd_writeback_q, rd_writeback_d;
  logic [DW-1:0] writeback_data_q, writeback_data_d;
  logic          mem_fault_q, mem_fault_d;

  assign mem_op = write_memory_enable_mem || (wb_sel_memory == WB_MEM);

  // Request is gated by reset so it drops the moment reset asserts
  assign dmem_bus.dmem_req   = reset && mem_op && (state_q != ABORT);
  assign dmem_bus.dmem_we    = write_memory_enable_mem;
  assign dmem_bus.dmem_addr  = alu_result_memory;
  assign dmem_bus.dmem_wdata = srcB_memory;

  assign fire      = dmem_bus.dmem_req && dmem_bus.dmem_ready;
  assign stall_mem = dmem_bus.dmem_req && !fire;

  assign timer_clear  = (state_q != WAIT);
  assign timer_enable = (state_q == WAIT) && !dmem_bus.dmem_ready;

  mem_wait_timer #(
    .TERMINAL (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tc     (tc)
  );

  // Next-state logic; ready beats timeout when both happen in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op && !fire) state_d = WAIT;
      WAIT:    if (dmem_bus.dmem_ready) state_d = IDLE;
               else if (tc) state_d = ABORT;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MEM/WB next value: abort retire, stall bubble, completed access, or plain op
  always_comb begin
    wre_writeback_d  = 1'b0;
    rd_writeback_d   = '0;
    writeback_data_d = '0;
    mem_fault_d      = mem_fault_q;
    if (state_q == ABORT) begin
      mem_fault_d = 1'b1;
    end else if (stall_mem) begin
      wre_writeback_d = 1'b0;
    end else if (mem_op) begin
      rd_writeback_d = rd_memory;
      if (!write_memory_enable_mem) begin
        wre_writeback_d  = wre_memory;
        writeback_data_d = dmem_bus.dmem_rdata;
      end
    end else begin
      wre_writeback_d  = wre_memory;
      rd_writeback_d   = rd_memory;
      writeback_data_d = (wb_sel_memory == WB_PC) ? pc_inc_memory : alu_result_memory;
    end
  end

  // State, MEM/WB register and sticky fault flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      wre_writeback_q  <= 1'b0;
      rd_writeback_q   <= '0;
      writeback_data_q <= '0;
      mem_fault_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      wre_writeback_q  <= wre_writeback_d;
      rd_writeback_q   <= rd_writeback_d;
      writeback_data_q <= writeback_data_d;
      mem_fault_q      <= mem_fault_d;
    end
  end

  assign wre_writeback  = wre_writeback_q;
  assign rd_writeback   = rd_writeback_q;
  assign writeback_data = writeback_data_q;
  assign mem_fault      = mem_fault_q;

`ifdef MEMORY_ACCESS_STAGE_STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_mem && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= 16'h0000;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage with directed vectors.
// Build with MEMORY_ACCESS_STAGE_STALL_CNT_EN to exercise the stall counter.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wre_memory;
  logic [1:0]  wb_sel_memory;
  logic        write_memory_enable_mem;
  logic [15:0] alu_result_memory;
  logic [15:0] srcB_memory;
  logic [15:0] pc_inc_memory;
  logic [3:0]  rd_memory;
  logic        stall_mem;
  logic        wre_writeback;
  logic [3:0]  rd_writeback;
  logic [15:0] writeback_data;
  logic        mem_fault;
  logic [15:0] stall_count;

  int checks   = 0;
  int failures = 0;

  memory_access_stage_if #(.DW(16)) bus ();

  memory_access_stage #(
    .DW          (16),
    .RW          (4),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .wre_memory              (wre_memory),
    .wb_sel_memory           (wb_sel_memory),
    .write_memory_enable_mem (write_memory_enable_mem),
    .alu_result_memory       (alu_result_memory),
    .srcB_memory             (srcB_memory),
    .pc_inc_memory           (pc_inc_memory),
    .rd_memory               (rd_memory),
    .dmem_bus                (bus),
    .stall_mem               (stall_mem),
    .wre_writeback           (wre_writeback),
    .rd_writeback            (rd_writeback),
    .writeback_data          (writeback_data),
    .mem_fault               (mem_fault),
    .stall_count             (stall_count)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wre_memory              = 1'b0;
    wb_sel_memory           = 2'd0;
    write_memory_enable_mem = 1'b0;
    alu_result_memory       = 16'h0000;
    srcB_memory             = 16'h0000;
    pc_inc_memory           = 16'h0000;
    rd_memory               = 4'd0;
    bus.dmem_ready          = 1'b0;
    bus.dmem_rdata          = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    wb_sel_memory = 2'd1;
    wre_memory    = 1'b1;
    rd_memory     = 4'd5;
    repeat (2) next_cycle();
    checks++; if (bus.dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%0h exp=0", bus.dmem_req); end
    checks++; if (stall_mem !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%0h exp=0", stall_mem); end
    checks++; if (wre_writeback !== 1'b0 || rd_writeback !== 4'd0 || writeback_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_wb got=%0h/%0h/%0h exp=0/0/0", wre_writeback, rd_writeback, writeback_data); end
    checks++; if (mem_fault !== 1'b0 || stall_count !== 16'h0000) begin failures++; $display("[TB] FAIL reset_fault_cnt got=%0h/%0h exp=0/0", mem_fault, stall_count); end
    idle_inputs();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_alu_op();
    wre_memory = 1'b1; wb_sel_memory = 2'd0; alu_result_memory = 16'h1234; rd_memory = 4'd3; pc_inc_memory = 16'h0050;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || stall_mem !== 1'b0) begin failures++; $display("[TB] FAIL alu_req_stall got=%0h/%0h exp=0/0", bus.dmem_req, stall_mem); end
    next_cycle();
    checks++; if (wre_writeback !== 1'b1 || rd_writeback !== 4'd3 || writeback_data !== 16'h1234) begin failures++; $display("[TB] FAIL alu_wb got=%0h/%0h/%0h exp=1/3/1234", wre_writeback, rd_writeback, writeback_data); end
    wb_sel_memory = 2'd2; rd_memory = 4'd7; pc_inc_memory = 16'h0051; alu_result_memory = 16'h9999;
    next_cycle();
    checks++; if (wre_writeback !== 1'b1 || rd_writeback !== 4'd7 || writeback_data !== 16'h0051) begin failures++; $display("[TB] FAIL link_wb got=%0h/%0h/%0h exp=1/7/0051", wre_writeback, rd_writeback, writeback_data); end
    wb_sel_memory = 2'd3; rd_memory = 4'd8; alu_result_memory = 16'hA5A5;
    next_cycle();
    checks++; if (writeback_data !== 16'hA5A5 || rd_writeback !== 4'd8) begin failures++; $display("[TB] FAIL sel3_wb got=%0h/%0h exp=a5a5/8", writeback_data, rd_writeback); end
    idle_inputs();
  endtask

  task automatic test_load_zero_wait();
    wre_memory = 1'b1; wb_sel_memory = 2'd1; alu_result_memory = 16'h0010; rd_memory = 4'd5;
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 16'hBEEF;
    #1;
    checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 16'h0010) begin failures++; $display("[TB] FAIL load_bus got=%0h/%0h/%0h exp=1/0/0010", bus.dmem_req, bus.dmem_we, bus.dmem_addr); end
    checks++; if (stall_mem !== 1'b0) begin failures++; $display("[TB] FAIL load_stall got=%0h exp=0", stall_mem); end
    next_cycle();
    checks++; if (wre_writeback !== 1'b1 || rd_writeback !== 4'd5 || writeback_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL load_wb got=%0h/%0h/%0h exp=1/5/beef", wre_writeback, rd_writeback, writeback_data); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    wre_memory = 1'b1; wb_sel_memory = 2'd1; alu_result_memory = 16'h0011; rd_memory = 4'd1;
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 16'h1111;
    next_cycle();
    checks++; if (rd_writeback !== 4'd1 || writeback_data !== 16'h1111) begin failures++; $display("[TB] FAIL b2b_load got=%0h/%0h exp=1/1111", rd_writeback, writeback_data); end
    wb_sel_memory = 2'd0; alu_result_memory = 16'h2222; rd_memory = 4'd2; bus.dmem_ready = 1'b0;
    next_cycle();
    checks++; if (wre_writeback !== 1'b1 || rd_writeback !== 4'd2 || writeback_data !== 16'h2222) begin failures++; $display("[TB] FAIL b2b_alu got=%0h/%0h/%0h exp=1/2/2222", wre_writeback, rd_writeback, writeback_data); end
    idle_inputs();
  endtask

  task automatic test_store_wait();
    write_memory_enable_mem = 1'b1; wre_memory = 1'b1; wb_sel_memory = 2'd0;
    alu_result_memory = 16'h0020; srcB_memory = 16'h00AA; rd_memory = 4'd2; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_mem !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_wdata !== 16'h00AA) begin failures++; $display("[TB] FAIL store_stall%0d got=%0h/%0h/%0h exp=1/1/00aa", i, stall_mem, bus.dmem_we, bus.dmem_wdata); end
      next_cycle();
      checks++; if (wre_writeback !== 1'b0 || rd_writeback !== 4'd0) begin failures++; $display("[TB] FAIL store_bubble%0d got=%0h/%0h exp=0/0", i, wre_writeback, rd_writeback); end
    end
    bus.dmem_ready = 1'b1;
    #1;
    checks++; if (stall_mem !== 1'b0 || bus.dmem_req !== 1'b1) begin failures++; $display("[TB] FAIL store_done got=%0h/%0h exp=0/1", stall_mem, bus.dmem_req); end
    next_cycle();
    checks++; if (wre_writeback !== 1'b0) begin failures++; $display("[TB] FAIL store_wre got=%0h exp=0", wre_writeback); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    wre_memory = 1'b1; wb_sel_memory = 2'd1; alu_result_memory = 16'h0030; rd_memory = 4'd4;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = 16'hDEAD;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (stall_mem === 1'b1) stalls++;
      next_cycle();
    end
    checks++; if (stalls != 16) begin failures++; $display("[TB] FAIL timeout_stalls got=%0d exp=16", stalls); end
    #1;
    checks++; if (stall_mem !== 1'b0 || bus.dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL abort_cycle got=%0h/%0h exp=0/0", stall_mem, bus.dmem_req); end
    next_cycle();
    checks++; if (wre_writeback !== 1'b0 || mem_fault !== 1'b1) begin failures++; $display("[TB] FAIL abort_retire got=%0h/%0h exp=0/1", wre_writeback, mem_fault); end
    idle_inputs();
    wre_memory = 1'b1; alu_result_memory = 16'h5555; rd_memory = 4'd6;
    #1;
    checks++; if (stall_mem !== 1'b0) begin failures++; $display("[TB] FAIL after_abort_stall got=%0h exp=0", stall_mem); end
    next_cycle();
    checks++; if (wre_writeback !== 1'b1 || writeback_data !== 16'h5555 || mem_fault !== 1'b1) begin failures++; $display("[TB] FAIL after_abort_wb got=%0h/%0h/%0h exp=1/5555/1", wre_writeback, writeback_data, mem_fault); end
    idle_inputs();
  endtask

  task automatic test_stall_count();
    logic [15:0] expected;
`ifdef MEMORY_ACCESS_STAGE_STALL_CNT_EN
    expected = 16'd19;
`else
    expected = 16'd0;
`endif
    checks++; if (stall_count !== expected) begin failures++; $display("[TB] FAIL stall_count got=%0d exp=%0d", stall_count, expected); end
  endtask

  task automatic test_reset_during_wait();
    wre_memory = 1'b1; wb_sel_memory = 2'd1; alu_result_memory = 16'h0040; rd_memory = 4'd9;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = 16'h1357;
    repeat (2) next_cycle();
    reset = 1'b0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || stall_mem !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_req got=%0h/%0h exp=0/0", bus.dmem_req, stall_mem); end
    checks++; if (mem_fault !== 1'b0 || stall_count !== 16'h0000 || wre_writeback !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_out got=%0h/%0h/%0h exp=0/0/0", mem_fault, stall_count, wre_writeback); end
    next_cycle();
    reset = 1'b1;
    #1;
    checks++; if (bus.dmem_req !== 1'b1 || stall_mem !== 1'b1) begin failures++; $display("[TB] FAIL replay_req got=%0h/%0h exp=1/1", bus.dmem_req, stall_mem); end
    next_cycle();
    bus.dmem_ready = 1'b1;
    #1;
    checks++; if (stall_mem !== 1'b0) begin failures++; $display("[TB] FAIL replay_stall got=%0h exp=0", stall_mem); end
    next_cycle();
    checks++; if (wre_writeback !== 1'b1 || rd_writeback !== 4'd9 || writeback_data !== 16'h1357) begin failures++; $display("[TB] FAIL replay_wb got=%0h/%0h/%0h exp=1/9/1357", wre_writeback, rd_writeback, writeback_data); end
    idle_inputs();
  endtask

  // Scenario sequence; stall-count check relies on running right after store and timeout
  initial begin
    test_reset();
    test_alu_op();
    test_load_zero_wait();
    test_back_to_back();
    test_store_wait();
    test_timeout();
    test_stall_count();
    test_reset_during_wait();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
